// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter arbiter.
package uart_pkg;

   localparam int UART_BYTE_W = 8;

   typedef enum logic [1:0] {
      ARB_IDLE      = 2'd0,
      ARB_LOAD      = 2'd1,
      ARB_WAIT_BUSY = 2'd2,
      ARB_WAIT_DONE = 2'd3
   } arb_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: rotate requests so ptr sits at bit 0, take the lowest set bit,
// then rotate the index back into requester numbering.
module uart_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_idx
);

   localparam logic [IW:0] NL = (IW+1)'(N);

   logic [N-1:0]  w_rot;
   logic [IW-1:0] w_off;
   logic [IW-1:0] w_idx;
   logic          w_any;

   function automatic logic [IW-1:0] add_mod(input logic [IW-1:0] a, input logic [IW-1:0] b);
      logic [IW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= NL) s = s - NL;
      return s[IW-1:0];
   endfunction

   always_comb begin
      w_rot   = '0;
      w_off   = '0;
      w_idx   = '0;
      w_any   = |i_req;
      o_grant = '0;
      for (int k = 0; k < N; k++) w_rot[k] = i_req[add_mod(i_ptr, IW'(k))];
      for (int k = N-1; k >= 0; k--) begin
         if (w_rot[k]) w_off = IW'(k);
      end
      w_idx = add_mod(i_ptr, w_off);
      for (int k = 0; k < N; k++) o_grant[k] = w_any && (w_idx == IW'(k));
   end

   assign o_idx = w_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locking arbiter sharing one UART transmitter between NUM_REQ byte sources.
// A lock ends on req_last, on a burst limit, or when the owner stays silent too long.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_BURST    = 16,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_REQ-1:0]               i_req_valid,
   input  logic [UART_BYTE_W*NUM_REQ-1:0]   i_req_data,
   input  logic [NUM_REQ-1:0]               i_req_last,
   output logic [NUM_REQ-1:0]               o_req_ready,
   output logic [clog2(NUM_REQ)-1:0]        o_grant_id,
   output logic                             o_grant_active,
   output logic                             o_lock_drop,
   output logic [UART_BYTE_W-1:0]           o_tx_data_in,
   output logic                             o_tx_data_en_n,
   input  logic                             i_tx_busy
);

   localparam int            IW       = clog2(NUM_REQ);
   localparam int            TW       = clog2(IDLE_TIMEOUT) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

   arb_state_e             r_state;
   logic [IW-1:0]          r_ptr;
   logic [IW-1:0]          r_owner;
   logic                   r_lock;
   logic                   r_lock_drop;
   logic [7:0]             r_burst_cnt;
   logic [TW-1:0]          r_tmo_cnt;
   logic [UART_BYTE_W-1:0] r_tx_data;

   logic [NUM_REQ-1:0]     w_pick_grant;
   logic [NUM_REQ-1:0]     w_ready;
   logic [IW-1:0]          w_pick_idx;
   logic [IW-1:0]          w_win;
   logic [UART_BYTE_W-1:0] w_win_data;
   logic                   w_idle;
   logic                   w_accept;
   logic                   w_owner_valid;
   logic                   w_last;
   logic                   w_burst_end;
   logic                   w_timeout;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   uart_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .i_req   (i_req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_pick_grant),
      .o_idx   (w_pick_idx)
   );

   assign w_idle        = (r_state == ARB_IDLE);
   assign w_owner_valid = i_req_valid[r_owner];
   assign w_win         = r_lock ? r_owner : w_pick_idx;

   // While locked only the owner may transfer; everyone else is ignored.
   always_comb begin
      w_ready = '0;
      if (w_idle) begin
         if (r_lock) w_ready[r_owner] = w_owner_valid;
         else        w_ready          = w_pick_grant;
      end
   end

   always_comb begin
      w_win_data = '0;
      w_last     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == IW'(i)) begin
            w_win_data = i_req_data[i*UART_BYTE_W +: UART_BYTE_W];
            w_last     = i_req_last[i];
         end
      end
   end

   assign w_accept    = |(i_req_valid & w_ready);
   assign w_burst_end = (r_burst_cnt + 8'd1) == 8'(MAX_BURST);
   assign w_timeout   = r_lock && !w_owner_valid && (r_tmo_cnt == TW'(IDLE_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ARB_IDLE;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_lock      <= 1'b0;
         r_lock_drop <= 1'b0;
         r_burst_cnt <= '0;
         r_tmo_cnt   <= '0;
         r_tx_data   <= '0;
      end else begin
         r_lock_drop <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               if (w_accept) begin
                  r_owner   <= w_win;
                  r_tx_data <= w_win_data;
                  r_tmo_cnt <= '0;
                  r_state   <= ARB_LOAD;
                  if (w_last || w_burst_end) begin
                     r_lock      <= 1'b0;
                     r_burst_cnt <= '0;
                     r_ptr       <= wrap_inc(w_win);
                     r_lock_drop <= !w_last;
                  end else begin
                     r_lock      <= 1'b1;
                     r_burst_cnt <= r_burst_cnt + 8'd1;
                  end
               end else if (r_lock) begin
                  // Acceptance wins over the timeout, so this branch only sees a silent owner.
                  if (w_timeout) begin
                     r_lock      <= 1'b0;
                     r_burst_cnt <= '0;
                     r_tmo_cnt   <= '0;
                     r_ptr       <= wrap_inc(r_owner);
                     r_lock_drop <= 1'b1;
                  end else begin
                     r_tmo_cnt <= r_tmo_cnt + 1'b1;
                  end
               end
            end
            ARB_LOAD:      if (!i_tx_busy) r_state <= ARB_WAIT_BUSY;
            ARB_WAIT_BUSY: if (i_tx_busy)  r_state <= ARB_WAIT_DONE;
            ARB_WAIT_DONE: if (!i_tx_busy) r_state <= ARB_IDLE;
            default:       r_state <= ARB_IDLE;
         endcase
      end
   end

   assign o_req_ready    = w_ready;
   assign o_grant_id     = r_owner;
   assign o_grant_active = r_lock | !w_idle;
   assign o_lock_drop    = r_lock_drop;
   assign o_tx_data_in   = r_tx_data;
   assign o_tx_data_en_n = !((r_state == ARB_LOAD) && !i_tx_busy);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART transmitter and queue-driven requesters.
module tb_uart_tx_arbiter;

   localparam int NR  = 4;
   localparam int CPP = 16;

   logic            clk = 1'b0;
   logic            rstn;
   logic [NR-1:0]   req_valid;
   logic [8*NR-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic [1:0]      grant_id;
   logic            grant_active;
   logic            lock_drop;
   logic [7:0]      tx_data_in;
   logic            tx_data_en_n;
   logic            tx_busy;
   logic            tx_line;
   logic [9:0]      tx_sh;
   int              tx_clk;
   int              tx_bit;

   logic [8:0]      rq [NR][$];
   logic [15:0]     strobe_log[$];
   logic [15:0]     exp_q[$];
   logic [NR-1:0]   hs;
   int              drop_cnt;
   int              drop_at;
   int              checks = 0;
   int              errors = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .IDLE_TIMEOUT(32)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .i_req_valid    (req_valid),
      .i_req_data     (req_data),
      .i_req_last     (req_last),
      .o_req_ready    (req_ready),
      .o_grant_id     (grant_id),
      .o_grant_active (grant_active),
      .o_lock_drop    (lock_drop),
      .o_tx_data_in   (tx_data_in),
      .o_tx_data_en_n (tx_data_en_n),
      .i_tx_busy      (tx_busy)
   );

   // Transmitter: start, 8 data bits LSB first, stop; CPP clocks per bit.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_busy <= 1'b0;
         tx_sh   <= '1;
         tx_clk  <= 0;
         tx_bit  <= 0;
      end else if (!tx_busy) begin
         if (!tx_data_en_n) begin
            tx_sh   <= {1'b1, tx_data_in, 1'b0};
            tx_busy <= 1'b1;
            tx_clk  <= 0;
            tx_bit  <= 0;
         end
      end else if (tx_clk == CPP - 1) begin
         tx_clk <= 0;
         tx_sh  <= {1'b1, tx_sh[9:1]};
         if (tx_bit == 9) tx_busy <= 1'b0;
         else             tx_bit  <= tx_bit + 1;
      end else begin
         tx_clk <= tx_clk + 1;
      end
   end

   assign tx_line = tx_busy ? tx_sh[0] : 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Advance one cycle: retire last handshakes, present queue heads, then sample mid-cycle.
   task automatic cyc();
      logic [NR-1:0]   v;
      logic [NR-1:0]   l;
      logic [8*NR-1:0] d;
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      v = '0;
      l = '0;
      d = req_data;
      for (int i = 0; i < NR; i++) begin
         if (rq[i].size() > 0) begin
            v[i]         = 1'b1;
            d[i*8 +: 8]  = rq[i][0][7:0];
            l[i]         = rq[i][0][8];
         end
      end
      req_valid = v;
      req_data  = d;
      req_last  = l;
      #1;
      hs = req_valid & req_ready;
      if (!tx_data_en_n) strobe_log.push_back({6'b0, grant_id, tx_data_in});
      if (lock_drop) begin
         drop_cnt++;
         drop_at = strobe_log.size();
      end
   endtask

   task automatic run_idle(input string tag, input int max);
      int n;
      n = 0;
      while (n < max && !(all_empty() && hs == '0 && !tx_busy && !grant_active)) begin
         cyc();
         n++;
      end
      chk({tag, "_idle"}, {31'd0, all_empty() && !tx_busy && !grant_active}, 32'd1);
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_count"}, strobe_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), (i < strobe_log.size()) ? {16'd0, strobe_log[i]} : 32'hDEAD, {16'd0, exp_q[i]});
      strobe_log = {};
      exp_q      = {};
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      hs   = '0;
      for (int i = 0; i < NR; i++) rq[i] = {};
      req_valid = '0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      strobe_log = {};
      drop_cnt   = 0;
   endtask

   initial begin
      int          n;
      int          k;
      logic [7:0]  rx;
      rstn      = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      hs        = '0;
      drop_cnt  = 0;
      drop_at   = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_tx_data", {24'd0, tx_data_in}, 32'h0);
      chk("rst_en_n", {31'd0, tx_data_en_n}, 32'd1);
      chk("rst_ready", {28'd0, req_ready}, 32'h0);
      chk("rst_lock_drop", {31'd0, lock_drop}, 32'd0);
      chk("rst_grant_active", {31'd0, grant_active}, 32'd0);
      chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Single byte from requester 2, checked on the serial line too.
      rq[2].push_back(9'h1A5);
      cyc();
      chk("t1_ready", {28'd0, req_ready}, 32'b0100);
      cyc();
      chk("t1_strobe", {31'd0, tx_data_en_n}, 32'd0);
      chk("t1_data", {24'd0, tx_data_in}, 32'hA5);
      chk("t1_gid", {30'd0, grant_id}, 32'd2);
      cyc();
      chk("t1_strobe_end", {31'd0, tx_data_en_n}, 32'd1);
      n = 0;
      while (tx_line && n < 40) begin cyc(); n++; end
      repeat (8) cyc();
      chk("t1_start_bit", {31'd0, tx_line}, 32'd0);
      rx = '0;
      for (int b = 0; b < 8; b++) begin
         repeat (CPP) cyc();
         rx[b] = tx_line;
      end
      chk("t1_frame", {24'd0, rx}, 32'hA5);
      repeat (CPP) cyc();
      chk("t1_stop_bit", {31'd0, tx_line}, 32'd1);
      run_idle("t1", 300);
      strobe_log = {};
      // ptr now 3: with 0 and 3 both waiting, 3 must go first.
      rq[0].push_back(9'h150);
      rq[3].push_back(9'h153);
      run_idle("t1b", 600);
      exp_q = '{16'h0353, 16'h0050};
      check_log("t1b");

      // Four one-byte frames after reset, then requester 0 again.
      do_reset();
      rq[0].push_back(9'h110);
      rq[0].push_back(9'h114);
      rq[1].push_back(9'h111);
      rq[2].push_back(9'h112);
      rq[3].push_back(9'h113);
      run_idle("t2", 1500);
      exp_q = '{16'h0010, 16'h0111, 16'h0212, 16'h0313, 16'h0014};
      check_log("t2");

      // Locked 3-byte frame from requester 1 (ptr=1) with 0 and 2 waiting.
      rq[1].push_back(9'h011);
      rq[1].push_back(9'h022);
      rq[1].push_back(9'h133);
      rq[0].push_back(9'h1A0);
      rq[2].push_back(9'h1A2);
      run_idle("t3", 1500);
      exp_q = '{16'h0111, 16'h0122, 16'h0133, 16'h02A2, 16'h00A0};
      check_log("t3");

      // Burst limit 4 cuts requester 0's 6-byte frame; requester 3 slips in.
      drop_cnt = 0;
      for (int i = 1; i <= 5; i++) rq[0].push_back(9'(i));
      rq[0].push_back(9'h106);
      cyc();
      rq[3].push_back(9'h13F);
      run_idle("t4", 2000);
      chk("t4_drop_cnt", drop_cnt, 32'd1);
      chk("t4_drop_after", drop_at, 32'd4);
      exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h033F, 16'h0005, 16'h0006};
      check_log("t4");

      // Owner 1 goes silent after byte 1; lock drops after 32 idle cycles, requester 2 follows.
      drop_cnt = 0;
      rq[1].push_back(9'h071);
      rq[2].push_back(9'h172);
      n = 0;
      while (!tx_busy && n < 50) begin cyc(); n++; end
      n = 0;
      while (tx_busy && n < 400) begin cyc(); n++; end
      // First busy-low sample is still WAIT_DONE; 32 idle samples follow, then the pulse.
      k = 1;
      while (!lock_drop && k < 100) begin cyc(); k++; end
      chk("t5_drop_delay", k, 32'd34);
      chk("t5_ready_after_drop", {28'd0, req_ready}, 32'b0100);
      run_idle("t5", 600);
      chk("t5_drop_cnt", drop_cnt, 32'd1);
      exp_q = '{16'h0171, 16'h0272};
      check_log("t5");

      // Reset while the transmitter is busy in WAIT_DONE.
      rq[2].push_back(9'h166);
      n = 0;
      while (!tx_busy && n < 50) begin cyc(); n++; end
      repeat (20) cyc();
      chk("t6_pre_active", {31'd0, grant_active}, 32'd1);
      chk("t6_pre_gid", {30'd0, grant_id}, 32'd2);
      rstn = 1'b0;
      #1;
      chk("t6_rst_tx_data", {24'd0, tx_data_in}, 32'h0);
      chk("t6_rst_en_n", {31'd0, tx_data_en_n}, 32'd1);
      chk("t6_rst_ready", {28'd0, req_ready}, 32'h0);
      chk("t6_rst_active", {31'd0, grant_active}, 32'd0);
      chk("t6_rst_gid", {30'd0, grant_id}, 32'd0);
      chk("t6_rst_drop", {31'd0, lock_drop}, 32'd0);
      hs = '0;
      strobe_log = {};
      repeat (2) cyc();
      rstn = 1'b1;
      rq[1].push_back(9'h161);
      rq[0].push_back(9'h160);
      run_idle("t6", 800);
      exp_q = '{16'h0060, 16'h0161};
      check_log("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
